unit_delay_scheduler: RTL and testbench

Multi-channel delay scheduler. Each channel is armed, drives its output low, then raises it after a programmed number of time units. Each channel's unit is a programmable multiple of a shared precision tick. This is the hardware counterpart of per-module timeunit/timeprecision delays: channels with different unit sizes (e.g. 10 vs 100 precision ticks) share one precision prescaler. It sits between the bench/control sequencer and the event outputs it gates.

---
 rtl/unit_delay_pkg.sv | 21 ++
 rtl/unit_delay_chan.sv | 104 ++++++++++
 rtl/unit_delay_scheduler.sv | 85 ++++++++
 tb/tb_unit_delay_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unit_delay_pkg.sv
// Shared types and default sizes for the unit delay scheduler and its channels.
// No logic here; channel state encoding and width helpers only.
package unit_delay_pkg;

  localparam int DEF_NCH      = 3;
  localparam int DEF_PREC_DIV = 1;
  localparam int DEF_UNIT_W   = 8;
  localparam int DEF_DLY_W    = 8;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_BUSY  = 2'd1,
    CH_FIRED = 2'd2
  } ch_state_e;

  // Index width that stays legal for a count of one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unit_delay_chan.sv
// One delay channel: arm loads counters, out/done rise one cycle after the last counted tick.
// Arm while counting is dropped; config writes are only presented by the parent when legal.
module unit_delay_chan
  import unit_delay_pkg::*;
#(
  parameter int UNIT_W = DEF_UNIT_W,
  parameter int DLY_W  = DEF_DLY_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              tick_i,
  input  logic              arm_i,
  input  logic              wr_i,
  input  logic [UNIT_W-1:0] wr_unit_i,
  input  logic [DLY_W-1:0]  wr_delay_i,
  output logic              busy_o,
  output logic              out_o,
  output logic              done_o
);

  ch_state_e         state_q, state_d;
  logic [UNIT_W-1:0] unit_q, unit_d;
  logic [UNIT_W-1:0] ucnt_q, ucnt_d;
  logic [DLY_W-1:0]  delay_q, delay_d;
  logic [DLY_W-1:0]  dcnt_q, dcnt_d;
  logic              busy_q, busy_d;
  logic              out_q, out_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    delay_d = delay_q;
    ucnt_d  = ucnt_q;
    dcnt_d  = dcnt_q;
    done_d  = 1'b0;

    if (wr_i) begin
      unit_d  = wr_unit_i;
      delay_d = wr_delay_i;
    end

    unique case (state_q)
      CH_IDLE, CH_FIRED: begin
        if (arm_i) begin
          ucnt_d = unit_q - UNIT_W'(1);
          dcnt_d = delay_q;
          if (delay_q == '0) begin
            state_d = CH_FIRED;
            done_d  = 1'b1;
          end else begin
            state_d = CH_BUSY;
          end
        end
      end
      CH_BUSY: begin
        // ucnt counts precision ticks within a unit; dcnt counts whole units.
        if (tick_i) begin
          if (ucnt_q != '0) begin
            ucnt_d = ucnt_q - UNIT_W'(1);
          end else begin
            ucnt_d = unit_q - UNIT_W'(1);
            dcnt_d = dcnt_q - DLY_W'(1);
            if (dcnt_q == DLY_W'(1)) begin
              state_d = CH_FIRED;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = CH_IDLE;
    endcase

    busy_d = (state_d == CH_BUSY);
    out_d  = (state_d == CH_FIRED);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= CH_IDLE;
      unit_q  <= UNIT_W'(1);
      delay_q <= DLY_W'(1);
      ucnt_q  <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      delay_q <= delay_d;
      ucnt_q  <= ucnt_d;
      dcnt_q  <= dcnt_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign out_o  = out_q;
  assign done_o = done_q;

endmodule

// File: rtl/unit_delay_scheduler.sv
// Multi-channel delay scheduler: shared precision prescaler, config decode, NCH channels.
// All outputs registered; rejected config writes pulse cfg_err one cycle later, nothing stalls.
module unit_delay_scheduler
  import unit_delay_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int PREC_DIV = DEF_PREC_DIV,
  parameter int UNIT_W   = DEF_UNIT_W,
  parameter int DLY_W    = DEF_DLY_W
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cfg_we_i,
  input  logic [idx_w(NCH)-1:0] cfg_ch_i,
  input  logic [UNIT_W-1:0]     cfg_unit_i,
  input  logic [DLY_W-1:0]      cfg_delay_i,
  output logic                  cfg_err_o,
  input  logic [NCH-1:0]        arm_i,
  output logic [NCH-1:0]        busy_o,
  output logic [NCH-1:0]        out_o,
  output logic [NCH-1:0]        done_o,
  output logic                  prec_tick_o
);

  localparam int                CH_W     = idx_w(NCH);
  localparam int                PRE_W    = idx_w(PREC_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PREC_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;
  logic [NCH-1:0]   wr;
  logic [NCH-1:0]   busy;

  // The tick flop mirrors "prescaler at its last phase", so it lines up with pre_q.
  always_comb begin
    pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
    tick_d = (pre_d == PRE_LAST);
  end

  // A same-cycle arm wins over a write to that channel; an out-of-range channel matches nothing.
  always_comb begin
    wr = '0;
    for (int i = 0; i < NCH; i++) begin
      wr[i] = cfg_we_i && (cfg_ch_i == CH_W'(i)) && (cfg_unit_i != '0) &&
              !busy[i] && !arm_i[i];
    end
    cfg_err_d = cfg_we_i && (wr == '0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pre_q     <= '0;
      tick_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    unit_delay_chan #(
      .UNIT_W (UNIT_W),
      .DLY_W  (DLY_W)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .tick_i     (tick_q),
      .arm_i      (arm_i[g]),
      .wr_i       (wr[g]),
      .wr_unit_i  (cfg_unit_i),
      .wr_delay_i (cfg_delay_i),
      .busy_o     (busy[g]),
      .out_o      (out_o[g]),
      .done_o     (done_o[g])
    );
  end

  assign busy_o      = busy;
  assign cfg_err_o   = cfg_err_q;
  assign prec_tick_o = tick_q;

endmodule

// File: tb/tb_unit_delay_scheduler.sv
// Bench for unit_delay_scheduler: one instance at PREC_DIV=1, one at PREC_DIV=4.
// done pulses are matched against a scoreboard of expected cycle windows.
module tb_unit_delay_scheduler;

  localparam int NCH = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we, cfg_err, prec_tick;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_unit, cfg_delay;
  logic [2:0] arm, busy, out, done;
  logic       cfg_we4, cfg_err4, prec_tick4;
  logic [1:0] cfg_ch4;
  logic [7:0] cfg_unit4, cfg_delay4;
  logic [2:0] arm4, busy4, out4, done4;

  always #5 clk = ~clk;

  unit_delay_scheduler #(.NCH(3), .PREC_DIV(1), .UNIT_W(8), .DLY_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
    .cfg_unit_i(cfg_unit), .cfg_delay_i(cfg_delay), .cfg_err_o(cfg_err),
    .arm_i(arm), .busy_o(busy), .out_o(out), .done_o(done), .prec_tick_o(prec_tick)
  );

  unit_delay_scheduler #(.NCH(3), .PREC_DIV(4), .UNIT_W(8), .DLY_W(8)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_we_i(cfg_we4), .cfg_ch_i(cfg_ch4),
    .cfg_unit_i(cfg_unit4), .cfg_delay_i(cfg_delay4), .cfg_err_o(cfg_err4),
    .arm_i(arm4), .busy_o(busy4), .out_o(out4), .done_o(done4), .prec_tick_o(prec_tick4)
  );

  typedef struct {
    int dut;
    int ch;
    int lo;
    int hi;
  } sb_t;

  typedef struct {
    int ch;
    int u;
    int d;
    bit err;
  } cfg_vec_t;

  typedef struct {
    int         off;
    logic [2:0] out;
    logic [2:0] busy;
  } tl_vec_t;

  sb_t      sb[$];
  cfg_vec_t cfg_tab[5];
  tl_vec_t  tl_tab[7];
  int       m_unit[NCH];
  int       m_dly[NCH];
  int       cyc   = 0;
  int       total = 0;
  int       bad   = 0;
  int       t0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cyc %0d", nm, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and match any done pulses to the scoreboard.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < NCH; i++) begin
          logic dn;
          int   idx;
          dn  = (d == 0) ? done[i] : done4[i];
          idx = -1;
          if (dn) begin
            for (int k = 0; k < sb.size(); k++)
              if (idx < 0 && sb[k].dut == d && sb[k].ch == i) idx = k;
            total++;
            if (idx < 0) begin
              bad++;
              $display("FAIL done_unexpected: dut%0d ch%0d pulsed at cyc %0d, none expected", d, i, cyc);
            end else begin
              if (cyc < sb[idx].lo || cyc > sb[idx].hi) begin
                bad++;
                $display("FAIL done_time: dut%0d ch%0d got cyc %0d want [%0d,%0d]",
                         d, i, cyc, sb[idx].lo, sb[idx].hi);
              end
              sb.delete(idx);
            end
          end
        end
      end
    end
  endtask

  task automatic wait_sb(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL done_missing: %0d pulses outstanding after %0d cycles", sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic cfg_write(input int ch, input int u, input int d, input bit exp_err);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_unit  = 8'(u);
    cfg_delay = 8'(d);
    step();
    cfg_we = 1'b0;
    chk("cfg_err", 32'(cfg_err), 32'(exp_err));
    if (!exp_err && ch < NCH) begin
      m_unit[ch] = u;
      m_dly[ch]  = d;
    end
  endtask

  task automatic arm1(input logic [2:0] m);
    for (int i = 0; i < NCH; i++) begin
      if (m[i]) begin
        int t;
        t = cyc + 1 + m_unit[i] * m_dly[i];
        sb.push_back('{dut: 0, ch: i, lo: t, hi: t});
      end
    end
    arm = m;
    step();
    arm = '0;
  endtask

  initial begin
    cfg_tab[0] = '{ch: 0, u: 100, d: 1, err: 1'b0};
    cfg_tab[1] = '{ch: 1, u: 10,  d: 1, err: 1'b0};
    cfg_tab[2] = '{ch: 2, u: 100, d: 1, err: 1'b0};
    cfg_tab[3] = '{ch: 1, u: 0,   d: 5, err: 1'b1};
    cfg_tab[4] = '{ch: 3, u: 20,  d: 1, err: 1'b1};

    tl_tab[0] = '{off: 0,   out: 3'b000, busy: 3'b111};
    tl_tab[1] = '{off: 9,   out: 3'b000, busy: 3'b111};
    tl_tab[2] = '{off: 10,  out: 3'b010, busy: 3'b101};
    tl_tab[3] = '{off: 11,  out: 3'b010, busy: 3'b101};
    tl_tab[4] = '{off: 99,  out: 3'b010, busy: 3'b101};
    tl_tab[5] = '{off: 100, out: 3'b111, busy: 3'b000};
    tl_tab[6] = '{off: 101, out: 3'b111, busy: 3'b000};

    for (int i = 0; i < NCH; i++) begin
      m_unit[i] = 1;
      m_dly[i]  = 1;
    end

    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_unit = '0; cfg_delay = '0; arm = '0;
    cfg_we4 = 1'b0; cfg_ch4 = '0; cfg_unit4 = '0; cfg_delay4 = '0; arm4 = '0;
    step();
    step();
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_tick", 32'(prec_tick), 32'd0);
    chk("rst_out4", 32'(out4), 32'd0);
    chk("rst_tick4", 32'(prec_tick4), 32'd0);
    rst_n = 1'b1;
    step();
    chk("tick_after_rst", 32'(prec_tick), 32'd1);

    for (int v = 0; v < 5; v++)
      cfg_write(cfg_tab[v].ch, cfg_tab[v].u, cfg_tab[v].d, cfg_tab[v].err);

    // Mixed unit sizes armed together.
    t0 = cyc;
    arm1(3'b111);
    for (int v = 0; v < 7; v++) begin
      while (cyc < t0 + 1 + tl_tab[v].off) step();
      chk($sformatf("tl_out@%0d", tl_tab[v].off), 32'(out), 32'(tl_tab[v].out));
      chk($sformatf("tl_busy@%0d", tl_tab[v].off), 32'(busy), 32'(tl_tab[v].busy));
      chk("tl_tick", 32'(prec_tick), 32'd1);
    end
    wait_sb(20);

    // Re-arm ch1 from FIRED, then a rejected busy write and an ignored arm.
    arm1(3'b010);
    chk("rearm1_out", 32'(out), 32'b101);
    step();
    cfg_write(1, 50, 1, 1'b1);
    arm = 3'b010;
    step();
    arm = '0;
    wait_sb(100);
    chk("busy_write_out", 32'(out), 32'b111);

    // Re-arm ch0 in FIRED: out drops next cycle and the full delay is counted again.
    cfg_write(0, 4, 3, 1'b0);
    arm1(3'b001);
    wait_sb(50);
    chk("ch0_fired", 32'(out[0]), 32'd1);
    arm1(3'b001);
    chk("ch0_rearm_low", 32'(out[0]), 32'd0);
    wait_sb(50);
    chk("ch0_rearm_high", 32'(out[0]), 32'd1);

    // Zero delay fires on the cycle after arm without ever reporting busy.
    cfg_write(0, 5, 0, 1'b0);
    arm1(3'b001);
    chk("d0_out", 32'(out[0]), 32'd1);
    chk("d0_busy", 32'(busy[0]), 32'd0);
    step();
    chk("d0_busy_after", 32'(busy[0]), 32'd0);

    // Same-cycle write and arm on ch2: arm uses the old setting, write is refused.
    t0 = cyc + 1 + m_unit[2] * m_dly[2];
    sb.push_back('{dut: 0, ch: 2, lo: t0, hi: t0});
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_unit = 8'd7; cfg_delay = 8'd1;
    arm = 3'b100;
    step();
    cfg_we = 1'b0;
    arm = '0;
    chk("same_cycle_err", 32'(cfg_err), 32'd1);
    wait_sb(300);
    arm1(3'b100);
    wait_sb(300);

    // PREC_DIV=4, unit=3 delay=2: arming k cycles after a tick gives latency 24-k.
    cfg_we4 = 1'b1; cfg_ch4 = 2'd0; cfg_unit4 = 8'd3; cfg_delay4 = 8'd2;
    step();
    cfg_we4 = 1'b0;
    chk("cfg4_err", 32'(cfg_err4), 32'd0);
    for (int p = 0; p < 4; p++) begin
      int n;
      int t;
      n = 0;
      while (!prec_tick4 && n < 10) begin
        step();
        n++;
      end
      chk("tick4_align", 32'(prec_tick4), 32'd1);
      repeat (p) step();
      t = cyc + 1 + 24 - p;
      sb.push_back('{dut: 1, ch: 0, lo: t, hi: t});
      arm4 = 3'b001;
      step();
      arm4 = '0;
      wait_sb(60);
      chk("ph_out4", 32'(out4[0]), 32'd1);
    end

    // Reset mid-count clears everything at once and no late done appears.
    arm1(3'b010);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_out", 32'(out), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_out4", 32'(out4), 32'd0);
    chk("async_tick", 32'(prec_tick), 32'd0);
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    repeat (25) step();
    chk("post_rst_out", 32'(out), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
